axi4_lite_master: RTL and testbench

AXI4-Lite initiator that turns single-beat command requests from an internal client into AXI4-Lite read and write transactions toward amba_adaptor and the register file. It lets on-chip sequencers load key, block and IV words and read result words over the same slave port a CPU uses. Only one transaction is outstanding at a time. Every AXI output is registered.

---
 rtl/axi4_lite_master.sv | 218 +++++++++++++++++++++
 tb/tb_axi4_lite_master.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one client command in, one AXI4-Lite transaction out, one response back.
// All AXI and client-facing outputs come straight from registers.
module axi4_lite_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [ADDR_W-9:0] OFFSET = '0
) (
    input  logic                ACLK,
    input  logic                ARSTn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [7:0]          cmd_addr,
    input  logic [DATA_W-1:0]   cmd_data,
    input  logic [DATA_W/8-1:0] cmd_strb,
    input  logic [2:0]          cmd_prot,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic [1:0]          rsp_resp,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic [2:0]          AWPROT,
    output logic                WVALID,
    input  logic                WREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    input  logic                BVALID,
    output logic                BREADY,
    input  logic [1:0]          BRESP,
    output logic                ARVALID,
    input  logic                ARREADY,
    output logic [ADDR_W-1:0]   ARADDR,
    output logic [2:0]          ARPROT,
    input  logic                RVALID,
    output logic                RREADY,
    input  logic [DATA_W-1:0]   RDATA,
    input  logic [1:0]          RRESP
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WRESP, S_READ, S_RDATA, S_RESP} state_t;

    state_t              state_reg, state_next;
    logic                cmd_ready_reg, cmd_ready_next;
    logic                rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0]   rsp_data_reg, rsp_data_next;
    logic [1:0]          rsp_resp_reg, rsp_resp_next;
    logic                awvalid_reg, awvalid_next;
    logic [ADDR_W-1:0]   awaddr_reg, awaddr_next;
    logic [2:0]          awprot_reg, awprot_next;
    logic                wvalid_reg, wvalid_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [STRB_W-1:0]   wstrb_reg, wstrb_next;
    logic                bready_reg, bready_next;
    logic                arvalid_reg, arvalid_next;
    logic [ADDR_W-1:0]   araddr_reg, araddr_next;
    logic [2:0]          arprot_reg, arprot_next;
    logic                rready_reg, rready_next;
    logic                aw_done_reg, aw_done_next;
    logic                w_done_reg, w_done_next;

    logic aw_fire, w_fire;
    assign aw_fire = awvalid_reg & AWREADY;
    assign w_fire  = wvalid_reg & WREADY;

    always_comb begin
        state_next     = state_reg;
        cmd_ready_next = cmd_ready_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_data_next  = rsp_data_reg;
        rsp_resp_next  = rsp_resp_reg;
        awvalid_next   = awvalid_reg;
        awaddr_next    = awaddr_reg;
        awprot_next    = awprot_reg;
        wvalid_next    = wvalid_reg;
        wdata_next     = wdata_reg;
        wstrb_next     = wstrb_reg;
        bready_next    = bready_reg;
        arvalid_next   = arvalid_reg;
        araddr_next    = araddr_reg;
        arprot_next    = arprot_reg;
        rready_next    = rready_reg;
        aw_done_next   = aw_done_reg;
        w_done_next    = w_done_reg;
        case (state_reg)
            S_IDLE: begin
                cmd_ready_next = 1'b1;
                if (cmd_valid && cmd_ready_reg) begin
                    cmd_ready_next = 1'b0;
                    if (cmd_write) begin
                        awaddr_next  = {OFFSET, cmd_addr};
                        awprot_next  = cmd_prot;
                        wdata_next   = cmd_data;
                        wstrb_next   = cmd_strb;
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                        aw_done_next = 1'b0;
                        w_done_next  = 1'b0;
                        state_next   = S_WRITE;
                    end else begin
                        araddr_next  = {OFFSET, cmd_addr};
                        arprot_next  = cmd_prot;
                        arvalid_next = 1'b1;
                        state_next   = S_READ;
                    end
                end
            end
            S_WRITE: begin
                // AW and W finish independently; the response phase waits for both.
                if (aw_fire) begin
                    awvalid_next = 1'b0;
                    aw_done_next = 1'b1;
                end
                if (w_fire) begin
                    wvalid_next = 1'b0;
                    w_done_next = 1'b1;
                end
                if ((aw_done_reg || aw_fire) && (w_done_reg || w_fire)) begin
                    bready_next = 1'b1;
                    state_next  = S_WRESP;
                end
            end
            S_WRESP: begin
                if (BVALID && bready_reg) begin
                    rsp_resp_next  = BRESP;
                    rsp_data_next  = '0;
                    bready_next    = 1'b0;
                    rsp_valid_next = 1'b1;
                    state_next     = S_RESP;
                end
            end
            S_READ: begin
                if (ARREADY && arvalid_reg) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    state_next   = S_RDATA;
                end
            end
            S_RDATA: begin
                if (RVALID && rready_reg) begin
                    rsp_data_next  = RDATA;
                    rsp_resp_next  = RRESP;
                    rready_next    = 1'b0;
                    rsp_valid_next = 1'b1;
                    state_next     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    cmd_ready_next = 1'b1;
                    state_next     = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARSTn) begin
            state_reg     <= S_IDLE;
            cmd_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_resp_reg  <= '0;
            awvalid_reg   <= 1'b0;
            awaddr_reg    <= '0;
            awprot_reg    <= '0;
            wvalid_reg    <= 1'b0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            bready_reg    <= 1'b0;
            arvalid_reg   <= 1'b0;
            araddr_reg    <= '0;
            arprot_reg    <= '0;
            rready_reg    <= 1'b0;
            aw_done_reg   <= 1'b0;
            w_done_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cmd_ready_reg <= cmd_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_resp_reg  <= rsp_resp_next;
            awvalid_reg   <= awvalid_next;
            awaddr_reg    <= awaddr_next;
            awprot_reg    <= awprot_next;
            wvalid_reg    <= wvalid_next;
            wdata_reg     <= wdata_next;
            wstrb_reg     <= wstrb_next;
            bready_reg    <= bready_next;
            arvalid_reg   <= arvalid_next;
            araddr_reg    <= araddr_next;
            arprot_reg    <= arprot_next;
            rready_reg    <= rready_next;
            aw_done_reg   <= aw_done_next;
            w_done_reg    <= w_done_next;
        end
    end

    assign cmd_ready = cmd_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_resp  = rsp_resp_reg;
    assign AWVALID   = awvalid_reg;
    assign AWADDR    = awaddr_reg;
    assign AWPROT    = awprot_reg;
    assign WVALID    = wvalid_reg;
    assign WDATA     = wdata_reg;
    assign WSTRB     = wstrb_reg;
    assign BREADY    = bready_reg;
    assign ARVALID   = arvalid_reg;
    assign ARADDR    = araddr_reg;
    assign ARPROT    = arprot_reg;
    assign RREADY    = rready_reg;
endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master: the bench plays the AXI slave and the client cycle by cycle.
module tb_axi4_lite_master;
    logic        ACLK = 1'b0;
    logic        ARSTn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [2:0]  AWPROT, ARPROT;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;

    int checks = 0;
    int failures = 0;

    always #5 ACLK = ~ACLK;

    axi4_lite_master dut (
        .ACLK(ACLK), .ARSTn(ARSTn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled at the falling edge.
    task automatic tick();
        @(posedge ACLK);
        @(negedge ACLK);
    endtask

    task automatic issue(input logic wr, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p);
        cmd_write = wr; cmd_addr = a; cmd_data = d; cmd_strb = s; cmd_prot = p;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        ARSTn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0;
        cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00;
        @(negedge ACLK);
        tick(); tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_awvalid", 32'(AWVALID), 32'd0);
        chk("rst_arvalid", 32'(ARVALID), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_bready", 32'(BREADY), 32'd0);
        ARSTn = 1'b1;
        tick();
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        $display("step reset: done");

        // Write, always-ready slave, stale BVALID present from the start.
        AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b00;
        chk("stale_b_ignored", 32'(BREADY), 32'd0);
        issue(1'b1, 8'h00, 32'h12345ABF, 4'b1101, 3'b011);
        chk("w1_awvalid", 32'(AWVALID), 32'd1);
        chk("w1_wvalid", 32'(WVALID), 32'd1);
        chk("w1_awaddr", AWADDR, 32'h0000_0000);
        chk("w1_wdata", WDATA, 32'h12345ABF);
        chk("w1_wstrb", 32'(WSTRB), 32'hD);
        chk("w1_awprot", 32'(AWPROT), 32'd3);
        chk("w1_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("w1_bready_early", 32'(BREADY), 32'd0);
        tick();
        chk("w1_awvalid_drop", 32'(AWVALID), 32'd0);
        chk("w1_wvalid_drop", 32'(WVALID), 32'd0);
        chk("w1_bready", 32'(BREADY), 32'd1);
        chk("w1_rsp_early", 32'(rsp_valid), 32'd0);
        tick();
        chk("w1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("w1_rsp_resp", 32'(rsp_resp), 32'd0);
        chk("w1_rsp_data", rsp_data, 32'd0);
        chk("w1_bready_drop", 32'(BREADY), 32'd0);
        BVALID = 1'b0; rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("w1_rsp_done", 32'(rsp_valid), 32'd0);
        chk("w1_cmd_ready_back", 32'(cmd_ready), 32'd1);
        $display("step write_fast: addr=00 data=12345abf resp=%0d", rsp_resp);

        // Write with W accepted first, AW much later, DECERR response.
        AWREADY = 1'b0; WREADY = 1'b0;
        issue(1'b1, 8'h14, 32'h4567A9AB, 4'b1111, 3'b000);
        chk("w2_awvalid", 32'(AWVALID), 32'd1);
        WREADY = 1'b1;
        tick();
        WREADY = 1'b0;
        chk("w2_wvalid_drop", 32'(WVALID), 32'd0);
        chk("w2_awvalid_hold1", 32'(AWVALID), 32'd1);
        chk("w2_awaddr", AWADDR, 32'h0000_0014);
        chk("w2_bready_wait1", 32'(BREADY), 32'd0);
        tick();
        chk("w2_awvalid_hold2", 32'(AWVALID), 32'd1);
        chk("w2_bready_wait2", 32'(BREADY), 32'd0);
        tick();
        chk("w2_awvalid_hold3", 32'(AWVALID), 32'd1);
        chk("w2_awaddr_stable", AWADDR, 32'h0000_0014);
        chk("w2_wvalid_stays_low", 32'(WVALID), 32'd0);
        AWREADY = 1'b1;
        tick();
        AWREADY = 1'b0;
        chk("w2_awvalid_drop", 32'(AWVALID), 32'd0);
        chk("w2_bready", 32'(BREADY), 32'd1);
        BVALID = 1'b1; BRESP = 2'b11;
        tick();
        BVALID = 1'b0;
        chk("w2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("w2_rsp_resp", 32'(rsp_resp), 32'd3);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("w2_cmd_ready_back", 32'(cmd_ready), 32'd1);
        $display("step write_slow_aw: addr=14 resp=%0d", rsp_resp);

        // Read with ARREADY delayed.
        issue(1'b0, 8'h20, 32'h0, 4'h0, 3'b011);
        chk("r1_arvalid", 32'(ARVALID), 32'd1);
        chk("r1_araddr", ARADDR, 32'h0000_0020);
        chk("r1_arprot", 32'(ARPROT), 32'd3);
        chk("r1_awvalid_idle", 32'(AWVALID), 32'd0);
        tick();
        chk("r1_arvalid_hold1", 32'(ARVALID), 32'd1);
        chk("r1_rready_wait", 32'(RREADY), 32'd0);
        tick();
        chk("r1_arvalid_hold2", 32'(ARVALID), 32'd1);
        ARREADY = 1'b1;
        tick();
        ARREADY = 1'b0;
        chk("r1_arvalid_drop", 32'(ARVALID), 32'd0);
        chk("r1_rready", 32'(RREADY), 32'd1);
        RVALID = 1'b1; RDATA = 32'h12BCDF78; RRESP = 2'b00;
        tick();
        RVALID = 1'b0;
        chk("r1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("r1_rsp_data", rsp_data, 32'h12BCDF78);
        chk("r1_rsp_resp", 32'(rsp_resp), 32'd0);
        chk("r1_rready_drop", 32'(RREADY), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        $display("step read_slow_ar: addr=20 data=%h resp=%0d", rsp_data, rsp_resp);

        // Read returning SLVERR; RVALID is left high afterwards as stale input.
        ARREADY = 1'b1; RVALID = 1'b1; RDATA = 32'hA5A50F0F; RRESP = 2'b10;
        issue(1'b0, 8'h00, 32'h0, 4'h0, 3'b001);
        chk("r2_arprot", 32'(ARPROT), 32'd1);
        chk("r2_araddr", ARADDR, 32'h0000_0000);
        tick();
        chk("r2_rready", 32'(RREADY), 32'd1);
        tick();
        ARREADY = 1'b0;
        chk("r2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("r2_rsp_resp", 32'(rsp_resp), 32'd2);
        chk("r2_rsp_data", rsp_data, 32'hA5A50F0F);
        $display("step read_slverr: addr=00 data=%h resp=%0d", rsp_data, rsp_resp);

        // Response back-pressure with the next command already waiting.
        cmd_write = 1'b1; cmd_addr = 8'h08; cmd_data = 32'hCAFEF00D; cmd_strb = 4'b0011;
        cmd_prot = 3'b010; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data", rsp_data, 32'hA5A50F0F);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_rready_stale", 32'(RREADY), 32'd0);
        end
        RVALID = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_rsp_consumed", 32'(rsp_valid), 32'd0);
        chk("bp_cmd_ready_back", 32'(cmd_ready), 32'd1);
        chk("bp_not_yet_issued", 32'(AWVALID), 32'd0);
        tick();
        cmd_valid = 1'b0;
        chk("bp_next_awvalid", 32'(AWVALID), 32'd1);
        chk("bp_next_awaddr", AWADDR, 32'h0000_0008);
        chk("bp_next_wdata", WDATA, 32'hCAFEF00D);
        chk("bp_next_wstrb", 32'(WSTRB), 32'h3);
        chk("bp_next_cmd_ready", 32'(cmd_ready), 32'd0);
        $display("step backpressure: next write accepted addr=%h", AWADDR);

        // Reset while the write is stalled (AWREADY/WREADY low).
        tick();
        chk("mid_awvalid_hold", 32'(AWVALID), 32'd1);
        ARSTn = 1'b0;
        tick();
        chk("mr_awvalid", 32'(AWVALID), 32'd0);
        chk("mr_wvalid", 32'(WVALID), 32'd0);
        chk("mr_awaddr", AWADDR, 32'd0);
        chk("mr_wdata", WDATA, 32'd0);
        chk("mr_wstrb", 32'(WSTRB), 32'd0);
        chk("mr_rsp_data", rsp_data, 32'd0);
        chk("mr_rsp_resp", 32'(rsp_resp), 32'd0);
        chk("mr_cmd_ready", 32'(cmd_ready), 32'd0);
        ARSTn = 1'b1;
        tick();
        chk("mr_cmd_ready_back", 32'(cmd_ready), 32'd1);
        ARREADY = 1'b1; RVALID = 1'b1; RDATA = 32'h0BADBEEF; RRESP = 2'b00;
        issue(1'b0, 8'h30, 32'h0, 4'h0, 3'b000);
        chk("mr_read_araddr", ARADDR, 32'h0000_0030);
        tick();
        tick();
        ARREADY = 1'b0; RVALID = 1'b0;
        chk("mr_read_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("mr_read_rsp_data", rsp_data, 32'h0BADBEEF);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("mr_read_idle", 32'(cmd_ready), 32'd1);
        $display("step reset_mid_write: fresh read data=%h", rsp_data);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
